// File: rtl/mem_port_arbiter_if.sv
// Shared RAM port bundle: I/D requester handshakes plus the RAM strobe side.
// slave = arbiter, master = requesters and RAM.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 6
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic              i_done;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [OP_W-1:0]   d_op;
  logic [1:0]        d_size;
  logic              d_grant;
  logic              d_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [OP_W-1:0]   RAM_OpCode;
  logic              RAM_enable;
  logic              MFC;
  logic              mem_trap;
  logic [1:0]        trap_cause;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_op, d_size, MFC,
    output i_grant, i_done, d_grant, d_done,
    output ram_addr, RAM_OpCode, RAM_enable,
    output mem_trap, trap_cause
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_op, d_size, MFC,
    input  i_grant, i_done, d_grant, d_done,
    input  ram_addr, RAM_OpCode, RAM_enable,
    input  mem_trap, trap_cause
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared between instruction fetch (I) and load/store (D).
// Optional WAIT-state timeout trap enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned     ADDR_W     = 32,
  parameter int unsigned     OP_W       = 6,
  parameter logic [OP_W-1:0] IFETCH_OP  = '0,
  parameter int unsigned     STARVE_MAX = 4,
  parameter int unsigned     TIMEOUT    = 16
) (
  input logic               Clk,
  input logic               RESET_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } state_e;

  state_e            state_q, state_d;
  logic              own_d_q, own_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [1:0]        size_q, size_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [1:0]        cause_q, cause_d;
  logic              misal;
  logic              d_win;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    case (size_q)
      2'b00:   misal = 1'b0;
      2'b01:   misal = addr_q[0];
      2'b10:   misal = |addr_q[1:0];
      default: misal = |addr_q[2:0];
    endcase
  end

  // D has priority until I has watched STARVE_MAX D grants go by
  assign d_win = bus.d_req &&
                 !(bus.i_req && starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    addr_d   = addr_q;
    op_d     = op_q;
    size_d   = size_q;
    starve_d = starve_q;
    cause_d  = cause_q;
`ifdef MEM_TIMEOUT_EN
    tmo_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (d_win) begin
          own_d_d = 1'b1;
          addr_d  = bus.d_addr;
          op_d    = bus.d_op;
          size_d  = bus.d_size;
          if (bus.i_req) starve_d = starve_q + 1'b1;
          state_d = ISSUE;
        end else if (bus.i_req) begin
          own_d_d  = 1'b0;
          addr_d   = bus.i_addr;
          op_d     = IFETCH_OP;
          size_d   = 2'b10;
          starve_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (misal) begin
          cause_d = 2'b01;
          state_d = ERR;
        end else begin
          state_d = WAIT;
        end
      end
`ifdef MEM_TIMEOUT_EN
      WAIT: begin
        if (bus.MFC) begin
          state_d = DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          cause_d = 2'b10;
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`else
      WAIT: begin
        if (bus.MFC) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      op_q     <= '0;
      size_q   <= '0;
      starve_q <= '0;
      cause_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      size_q   <= size_d;
      starve_q <= starve_d;
      cause_q  <= cause_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

  assign bus.i_grant    = (state_q != IDLE) && !own_d_q;
  assign bus.d_grant    = (state_q != IDLE) && own_d_q;
  assign bus.i_done     = (state_q == DONE) && !own_d_q;
  assign bus.d_done     = (state_q == DONE) && own_d_q;
  assign bus.ram_addr   = addr_q;
  assign bus.RAM_OpCode = op_q;
  assign bus.RAM_enable = (state_q == WAIT);
  assign bus.mem_trap   = (state_q == ERR);
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-requester expectation queues,
// rule-level arbitration model, directed corner cases then random traffic.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int OP_W   = 6;
  localparam logic [5:0] IFETCH_OP = 6'b000000;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .OP_W(OP_W), .IFETCH_OP(IFETCH_OP),
    .STARVE_MAX(STARVE_MAX), .TIMEOUT(16)
  ) dut (
    .Clk(clk), .RESET_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  op;
    int          cause;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int mfc_dly = 0;
  bit mfc_rand = 0;
  bit mfc_noise = 0;
  int i_done_cnt = 0;
  int trap_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic fail(input string nm);
    total++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic issue_i(input logic [31:0] a, input int cause);
    exp_t e;
    e = '{a, IFETCH_OP, cause};
    bus.i_addr = a;
    bus.i_req = 1'b1;
    iq.push_back(e);
  endtask

  task automatic issue_d(input logic [31:0] a, input logic [1:0] sz,
                         input logic [5:0] op);
    exp_t e;
    int c;
    c = ((a % (32'd1 << sz)) != 0) ? 1 : 0;
    e = '{a, op, c};
    bus.d_addr = a;
    bus.d_size = sz;
    bus.d_op = op;
    bus.d_req = 1'b1;
    dq.push_back(e);
  endtask

  // 0: I ends, 1: D ends, 2: i_grant, 3: RAM_enable
  task automatic wait_sig(input int which, input string nm, output int t);
    bit hit;
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      case (which)
        0: hit = bus.i_done || (bus.mem_trap && bus.i_grant);
        1: hit = bus.d_done || (bus.mem_trap && bus.d_grant);
        2: hit = bus.i_grant;
        default: hit = bus.RAM_enable;
      endcase
      if (hit) begin
        t = cyc;
        return;
      end
    end
    fail(nm);
  endtask

  // RAM model: MFC arrives mfc_dly cycles after RAM_enable is first seen
  initial begin
    int en_cnt;
    en_cnt = 0;
    bus.MFC = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.RAM_enable) begin
        if (en_cnt == 0 && mfc_rand) mfc_dly = $urandom_range(0, 3);
        en_cnt++;
        bus.MFC = (en_cnt == mfc_dly + 1);
      end else begin
        en_cnt = 0;
        bus.MFC = mfc_noise && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: arbitration rule model and completion scoreboard
  initial begin
    bit prev_g, saw_en, is_i;
    int starve;
    exp_t cur;
    prev_g = 0;
    saw_en = 0;
    starve = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_g = 0;
        saw_en = 0;
        starve = 0;
        continue;
      end
      if ((bus.i_grant || bus.d_grant) && !prev_g) begin
        chk("grant_excl", bus.i_grant & bus.d_grant, 0);
        chk("arb_winner", bus.i_grant,
            !bus.d_req || (starve == STARVE_MAX && bus.i_req));
        if (bus.i_grant) starve = 0;
        else if (bus.i_req) starve++;
        saw_en = 0;
      end
      prev_g = bus.i_grant || bus.d_grant;
      if (bus.RAM_enable) saw_en = 1;
      if (bus.i_done || bus.d_done || bus.mem_trap) begin
        is_i = bus.i_done || (bus.mem_trap && bus.i_grant);
        if (is_i && iq.size() == 0) fail("unexpected_i_completion");
        else if (!is_i && dq.size() == 0) fail("unexpected_d_completion");
        else begin
          if (is_i) cur = iq.pop_front();
          else cur = dq.pop_front();
          chk(is_i ? "i_ram_addr" : "d_ram_addr", bus.ram_addr, cur.addr);
          chk(is_i ? "i_opcode" : "d_opcode", bus.RAM_OpCode, cur.op);
          chk(is_i ? "i_cause" : "d_cause",
              bus.mem_trap ? 64'(bus.trap_cause) : 64'd0, cur.cause);
          chk("ram_enable_used", saw_en, cur.cause != 1);
        end
        if (bus.i_done) i_done_cnt++;
        if (bus.mem_trap) trap_cnt++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, n, n2;
    bit got_i;
    bus.i_req = 0;
    bus.i_addr = 0;
    bus.d_req = 0;
    bus.d_addr = 0;
    bus.d_op = 0;
    bus.d_size = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {bus.i_grant, bus.d_grant, bus.i_done, bus.d_done,
        bus.RAM_enable, bus.mem_trap, bus.trap_cause, bus.RAM_OpCode}, 0);
    chk("rst_addr", bus.ram_addr, 0);
    rst_n = 1;
    @(negedge clk);

    // single fetch, MFC two cycles after RAM_enable
    mfc_dly = 2;
    n = i_done_cnt;
    t0 = cyc;
    issue_i(32'h40, 0);
    wait_sig(0, "t1_done", t1);
    bus.i_req = 0;
    chk("t1_latency", t1 - t0, 5);
    repeat (3) @(negedge clk);
    chk("t1_done_once", i_done_cnt - n, 1);

    // simultaneous I and D: D first, one IDLE gap before I
    mfc_dly = 1;
    n2 = i_done_cnt;
    issue_d(32'h180, 2'b10, 6'h21);
    issue_i(32'h44, 0);
    wait_sig(1, "t2_d", t0);
    bus.d_req = 0;
    chk("t2_d_first", i_done_cnt - n2, 0);
    wait_sig(2, "t2_igrant", t1);
    chk("t2_gap", t1 - t0, 2);
    wait_sig(0, "t2_i", t1);
    bus.i_req = 0;
    @(negedge clk);

    // starvation: D held continuously while I waits
    mfc_dly = 0;
    n = 0;
    got_i = 0;
    issue_d(32'h200, 2'b11, 6'h10);
    issue_i(32'h48, 0);
    for (int k = 0; k < 200 && !got_i; k++) begin
      @(negedge clk);
      if (bus.i_grant) got_i = 1;
      else if (bus.d_done) begin
        n++;
        issue_d(32'h200 + 32'(n * 8), 2'b11, 6'h10);
      end
    end
    if (!got_i) fail("t3_i_grant");
    chk("t3_d_before_i", n, 4);
    wait_sig(0, "t3_i", t1);
    bus.i_req = 0;
    wait_sig(1, "t3_d", t1);
    bus.d_req = 0;
    @(negedge clk);

    // misaligned word access
    issue_d(32'h182, 2'b10, 6'h22);
    wait_sig(1, "t4_trap", t1);
    chk("t4_trap", bus.mem_trap, 1);
    chk("t4_cause", bus.trap_cause, 2'b01);
    chk("t4_no_done", bus.d_done, 0);
    bus.d_req = 0;
    @(negedge clk);

    mfc_dly = 1000;
`ifdef MEM_TIMEOUT_EN
    t0 = cyc;
    issue_i(32'h50, 2);
    wait_sig(0, "t5_tmo", t1);
    chk("t5_tmo_latency", t1 - t0, 18);
    chk("t5_tmo_cause", bus.trap_cause, 2'b10);
    bus.i_req = 0;
    @(negedge clk);
    chk("t5_en_drop", {bus.RAM_enable, bus.i_grant}, 0);
    issue_i(32'h60, 0);
    wait_sig(3, "t6_en", t1);
    repeat (3) @(negedge clk);
`else
    n = trap_cnt;
    issue_i(32'h60, 0);
    wait_sig(3, "t5_en", t1);
    repeat (40) @(negedge clk);
    chk("t5_hold_en", bus.RAM_enable, 1);
    chk("t5_no_trap", trap_cnt - n, 0);
`endif

    // asynchronous reset in WAIT, pending fetch served afterwards
    rst_n = 0;
    #1;
    chk("t6_async_ctl", {bus.i_grant, bus.d_grant, bus.i_done, bus.d_done,
        bus.RAM_enable, bus.mem_trap, bus.trap_cause, bus.RAM_OpCode}, 0);
    chk("t6_async_addr", bus.ram_addr, 0);
    iq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    mfc_dly = 1;
    issue_i(32'h60, 0);
    rst_n = 1;
    wait_sig(0, "t6_after", t1);
    chk("t6_served", bus.i_done, 1);
    bus.i_req = 0;
    @(negedge clk);

    // random traffic
    mfc_rand = 1;
    mfc_noise = 1;
    fork
      begin
        int t;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue_i({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 0);
          wait_sig(0, "rnd_i", t);
          bus.i_req = 0;
        end
      end
      begin
        int t;
        logic [1:0] sz;
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          sz = 2'($urandom_range(0, 3));
          a = 32'($urandom_range(0, 4095));
          if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 1);
          issue_d(a, sz, 6'($urandom_range(0, 63)));
          wait_sig(1, "rnd_d", t);
          bus.d_req = 0;
        end
      end
    join
    mfc_noise = 0;
    repeat (5) @(negedge clk);
    chk("queues_drained", iq.size() + dq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
